// File: rtl/serial_rca_adder.sv
// Bit-serial ripple-carry adder: one full-adder slice plus a carry flip-flop, LSB first.
// Optional SERIAL_SUB_EN adds a 'sub' input that turns the slice into a full subtractor.
module serial_rca_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Handshake: start is sampled on a rising edge only while the FSM sits in
  // IDLE or DONE; in RUN it is ignored. done is a single-cycle pulse in DONE,
  // and sum/cout are valid from that cycle until the next completion.

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-2:0] r_sh;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
`ifdef SERIAL_SUB_EN
  logic             sub_q;
`endif

  logic             a0, b0;
  logic             s_bit;
  logic             c_next;
  logic             last_bit;
  logic             accept;
  logic [WIDTH-1:0] r_full;

  assign a0       = a_sh[0];
  assign b0       = b_sh[0];
  assign s_bit    = a0 ^ b0 ^ carry_q;
  assign last_bit = (cnt_q == CW'(WIDTH - 1));
  assign accept   = start && ((state_q == IDLE) || (state_q == DONE));
  // Result bits collected so far with the current bit at the MSB end; at the
  // last bit this is the complete sum.
  assign r_full   = {s_bit, r_sh};

  always_comb begin
    c_next = (a0 & b0) | (a0 & carry_q) | (b0 & carry_q);
`ifdef SERIAL_SUB_EN
    if (sub_q) begin
      c_next = (~a0 & carry_q) | (~a0 & b0) | (b0 & carry_q);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        if (last_bit) state_d = DONE;
      end
      DONE: begin
        state_d = start ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      r_sh    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else if (accept) begin
      a_sh    <= a;
      b_sh    <= b;
      r_sh    <= '0;
      carry_q <= cin;
      cnt_q   <= '0;
`ifdef SERIAL_SUB_EN
      sub_q   <= sub;
`endif
    end else if (state_q == RUN) begin
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      r_sh    <= r_full[WIDTH-1:1];
      carry_q <= c_next;
      cnt_q   <= cnt_q + CW'(1);
      if (last_bit) begin
        sum_q  <= r_full;
        cout_q <= c_next;
      end
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_rca_adder.sv
// Directed plus randomized bench for serial_rca_adder; the reference is plain
// (WIDTH+1)-bit arithmetic on the operands held in a scoreboard queue.
module tb_serial_rca_adder;

  localparam int WIDTH = 8;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             cin;
  logic             sub;
  logic             busy, done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic [1:0]       state_dbg;

  logic [WIDTH:0]   exp_q[$];
  logic [WIDTH:0]   last_res;
  int               checks = 0;
  int               errors = 0;

  always #5 clk = ~clk;

  serial_rca_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SERIAL_SUB_EN
    .sub       (sub),
`endif
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .cout      (cout),
    .state_dbg (state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [WIDTH:0] ref_model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic ci, input logic sb);
    int unsigned r;
    if (sb) r = x - y - ci;
    else    r = x + y + ci;
    return r[WIDTH:0];
  endfunction

  // Called at a negedge in IDLE or DONE; returns at the negedge of the first RUN cycle.
  task automatic start_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input logic ci, input logic sb);
    logic s_eff;
`ifdef SERIAL_SUB_EN
    s_eff = sb;
`else
    s_eff = 1'b0;
`endif
    a = x; b = y; cin = ci; sub = sb; start = 1'b1;
    exp_q.push_back(ref_model(x, y, ci, s_eff));
    @(negedge clk);
    start = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom);
    cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
    check("accept_state", {30'd0, state_dbg}, {30'd0, ST_RUN});
  endtask

  // Counts remaining RUN cycles, then checks the DONE cycle against the scoreboard.
  task automatic finish_op(input string tag, input int pre);
    int n;
    bit held;
    logic [WIDTH:0] expv;
    n = pre;
    held = 1'b1;
    while (busy === 1'b1 && n < 4 * WIDTH) begin
      if ({cout, sum} !== last_res) held = 1'b0;
      n++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, n, WIDTH);
    check({tag, "_hold"}, held, 1);
    check({tag, "_done"}, done, 1);
    expv = exp_q.pop_front();
    check({tag, "_sum"}, sum, expv[WIDTH-1:0]);
    check({tag, "_cout"}, cout, expv[WIDTH]);
    last_res = expv;
  endtask

  task automatic idle_after(input string tag);
    @(negedge clk);
    check({tag, "_done_low"}, done, 0);
    check({tag, "_idle"}, {30'd0, state_dbg}, {30'd0, ST_IDLE});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit quiet;
    bit b2b;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    last_res = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});

    start_op(8'h5A, 8'h33, 1'b0, 1'b0);
    finish_op("t1", 0);
    check("t1_sum_const", sum, 8'h8D);
    check("t1_cout_const", cout, 0);
    idle_after("t1");

    start_op(8'hFF, 8'h01, 1'b0, 1'b0);
    finish_op("t2", 0);
    check("t2_sum_const", sum, 8'h00);
    check("t2_cout_const", cout, 1);
    idle_after("t2");

    start_op(8'hFF, 8'hFF, 1'b1, 1'b0);
    finish_op("t3a", 0);
    check("t3a_sum_const", sum, 8'hFF);
    check("t3a_cout_const", cout, 1);
    start_op(8'h01, 8'h02, 1'b0, 1'b0);
    finish_op("t3b", 0);
    check("t3b_sum_const", sum, 8'h03);
    check("t3b_cout_const", cout, 0);
    idle_after("t3b");

    // Start pulse in the third RUN cycle must be ignored.
    start_op(8'h10, 8'h20, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    a = 8'hAA; b = 8'hAA; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_op("t4", 3);
    check("t4_sum_const", sum, 8'h30);
    check("t4_cout_const", cout, 0);
    idle_after("t4");
    quiet = 1'b1;
    repeat (WIDTH + 2) begin
      @(negedge clk);
      if (done !== 1'b0) quiet = 1'b0;
    end
    check("t4_single_done", quiet, 1);

    // Reset during the fourth RUN cycle aborts the operation.
    start_op(8'h5A, 8'h33, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(exp_q.pop_front());
    last_res = '0;
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_sum", sum, 0);
    check("t5_cout", cout, 0);
    check("t5_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});
    quiet = 1'b1;
    repeat (WIDTH + 4) begin
      @(negedge clk);
      if (done !== 1'b0) quiet = 1'b0;
    end
    check("t5_no_done", quiet, 1);

`ifdef SERIAL_SUB_EN
    start_op(8'h10, 8'h01, 1'b0, 1'b1);
    finish_op("s1", 0);
    check("s1_sum_const", sum, 8'h0F);
    check("s1_cout_const", cout, 0);
    idle_after("s1");
    start_op(8'h00, 8'h01, 1'b0, 1'b1);
    finish_op("s2", 0);
    check("s2_sum_const", sum, 8'hFF);
    check("s2_cout_const", cout, 1);
    idle_after("s2");
`endif

    for (int i = 0; i < 40; i++) begin
      start_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
      finish_op("rnd", 0);
      b2b = (i != 39) && ($urandom_range(0, 1) == 1);
      if (!b2b) begin
        idle_after("rnd");
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
